hp_alarm_log: RTL and testbench

HP_ALARM_LOG -- requirements
Module: hp_alarm_log

---
 rtl/hp_alarm_log.sv | 187 ++++++++++++++++++
 tb/tb_hp_alarm_log.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_alarm_log.sv
// hp_alarm_log: records a timestamp for every rising edge of an external
// alarm level in a small FIFO. Software reads the FIFO, status, the live
// timestamp and the control bits through a four-word Wishbone window.
module hp_alarm_log #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0010,
    parameter int          DEPTH     = 8,
    parameter int          TS_WIDTH  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        alarm,
    output logic        irq
);
    localparam int         PW         = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C    = 5'(DEPTH);
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_TIME   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // Synchroniser chain and free-running timestamp
    logic                s1_q, s2_q, s3_q;
    logic [TS_WIDTH-1:0] ts_q;

    // FIFO storage and bookkeeping
    logic [TS_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [4:0]          count_q, count_d;
    logic                overflow_q, overflow_d;

    // Control register and registered outputs
    logic                enable_q, enable_d;
    logic                irq_en_q, irq_en_d;
    logic                ack_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q, irq_d;

    // Decode and FIFO control strobes
    logic       req_s, hit_s, rd_s, wr_s;
    logic [1:0] sel_s;
    logic       empty_s, full_s, event_s;
    logic       pop_s, flush_s, ovf_clr_s;
    logic       push_req_s, push_s, drop_s;
    logic       unused_s;

    // Address bits below word granularity and unmapped write bits carry no meaning
    assign unused_s = ^{i_wb_addr[1:0], i_wb_data[31:17], i_wb_data[15:2]};

    // Bus decode, FIFO push/pop/flush arbitration and next-state values
    always_comb begin
        req_s   = i_wb_cyc & i_wb_stb;
        hit_s   = (i_wb_addr[31:4] == BASE_ADDR[31:4]);
        sel_s   = i_wb_addr[3:2];
        rd_s    = req_s & hit_s & ~i_wb_we;
        wr_s    = req_s & hit_s & i_wb_we;
        empty_s = (count_q == 5'd0);
        full_s  = (count_q == DEPTH_C);
        event_s = s2_q & ~s3_q;

        pop_s      = rd_s & (sel_s == REG_DATA) & ~empty_s;
        flush_s    = wr_s & (sel_s == REG_STATUS) & i_wb_data[0];
        ovf_clr_s  = wr_s & (sel_s == REG_STATUS) & i_wb_data[16];
        // A flush discards any event arriving on the same edge
        push_req_s = event_s & enable_q & ~flush_s;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the push
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end

        // A new drop on the same edge as a clear is still recorded
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (wr_s && (sel_s == REG_CTRL)) begin
            enable_d = i_wb_data[0];
            irq_en_d = i_wb_data[1];
        end else begin
            enable_d = enable_q;
            irq_en_d = irq_en_q;
        end

        rdata_d = 32'd0;
        if (rd_s) begin
            case (sel_s)
                REG_STATUS: rdata_d = {15'd0, overflow_q, 6'd0, full_s, empty_s, 3'd0, count_q};
                REG_DATA: begin
                    if (empty_s) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = 32'h8000_0000 | 32'(mem_q[rd_ptr_q]);
                    end
                end
                REG_TIME:   rdata_d = 32'(ts_q);
                REG_CTRL:   rdata_d = {30'd0, irq_en_q, enable_q};
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end

        irq_d = irq_en_q & (~empty_s | overflow_q);
    end

    // State update: synchroniser, timestamp, FIFO bookkeeping, control and bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            ts_q       <= {TS_WIDTH{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= alarm;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            ts_q       <= ts_q + TS_WIDTH'(1);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= req_s;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    // FIFO storage; left unreset because count gates every read of it
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_hp_alarm_log.sv
`timescale 1ns/1ps
module tb_hp_alarm_log;
    localparam logic [31:0] A_STATUS = 32'h3000_0010;
    localparam logic [31:0] A_DATA   = 32'h3000_0014;
    localparam logic [31:0] A_TIME   = 32'h3000_0018;
    localparam logic [31:0] A_CTRL   = 32'h3000_001C;
    localparam logic [31:0] A_MISSLO = 32'h3000_000C;
    localparam logic [31:0] A_MISSHI = 32'h3000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        alarm = 1'b0;
    logic        ack, stall, irq, ack_w, stall_w, irq_w;
    logic [31:0] rdata, rdata_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of timestamps plus flags and recent alarm samples
    int unsigned q[$];
    bit          ovf_m, en_m, irqen_m;
    bit          h0, h1, h2;
    int unsigned ts_m;

    always #5 clk = ~clk;

    hp_alarm_log u_dut (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack), .o_wb_stall(stall),
        .o_wb_data(rdata), .alarm(alarm), .irq(irq)
    );

    // Narrow-timestamp instance so the counter wrap is reachable quickly
    hp_alarm_log #(.TS_WIDTH(10)) u_dut_w (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack_w), .o_wb_stall(stall_w),
        .o_wb_data(rdata_w), .alarm(alarm), .irq(irq_w)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0; en_m = 1'b0; irqen_m = 1'b0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        ts_m = 0;
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = 32'd0;
        s[16]  = ovf_m;
        s[9]   = (q.size() == 8);
        s[8]   = (q.size() == 0);
        s[4:0] = 5'(q.size());
        return s;
    endfunction

    // One clock: predict from the model, cross the edge, compare, advance the model
    task automatic step();
        logic [31:0] e_data;
        logic        e_ack, e_irq, rd, wr, hit, evt, pop, flush, clr, smp;
        logic [1:0]  sel;
        hit    = (addr[31:4] == A_STATUS[31:4]);
        sel    = addr[3:2];
        rd     = cyc && stb && !we && hit;
        wr     = cyc && stb && we && hit;
        e_ack  = cyc && stb;
        e_data = 32'd0;
        pop    = 1'b0;
        if (rd) begin
            case (sel)
                2'd0: e_data = status_m();
                2'd1: begin
                    if (q.size() != 0) begin
                        e_data = 32'h8000_0000 | q[0];
                        pop = 1'b1;
                    end
                end
                2'd2: e_data = ts_m;
                default: e_data = {30'd0, irqen_m, en_m};
            endcase
        end
        e_irq = irqen_m && ((q.size() != 0) || ovf_m);
        evt   = en_m && h1 && !h2;
        flush = wr && (sel == 2'd0) && wdata[0];
        clr   = wr && (sel == 2'd0) && wdata[16];
        smp   = alarm;
        @(posedge clk);
        #1;
        check("ack", 32'(ack), 32'(e_ack));
        check("rdata", rdata, e_data);
        check("irq", 32'(irq), 32'(e_irq));
        check("stall", 32'(stall), 32'd0);
        if (pop) void'(q.pop_front());
        if (clr) ovf_m = 1'b0;
        if (flush) q.delete();
        else if (evt) begin
            if (q.size() < 8) q.push_back(ts_m);
            else ovf_m = 1'b1;
        end
        if (wr && (sel == 2'd3)) begin
            en_m    = wdata[0];
            irqen_m = wdata[1];
        end
        h2 = h1; h1 = h0; h0 = smp;
        ts_m = (ts_m + 1) & 32'h00FF_FFFF;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
        step();
        r = rdata;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Single-cycle alarm pulse; its timestamp will be t + 2
    task automatic pulse(output int unsigned t);
        t = ts_m;
        alarm = 1'b1;
        step();
        alarm = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  r, d1, d2, d3;
        int unsigned  t[10];
        int unsigned  tt;
        int           guard;
        vec_t         tbl[16];

        tbl[0]  = '{1'b1, A_CTRL,   32'd0,          32'd0};
        tbl[1]  = '{1'b0, A_CTRL,   32'd0,          32'd0};
        tbl[2]  = '{1'b1, A_CTRL,   32'hFFFF_FFFF,  32'd0};
        tbl[3]  = '{1'b0, A_CTRL,   32'd0,          32'h0000_0003};
        tbl[4]  = '{1'b1, A_MISSLO, 32'd0,          32'd0};
        tbl[5]  = '{1'b0, A_CTRL,   32'd0,          32'h0000_0003};
        tbl[6]  = '{1'b0, A_MISSLO, 32'd0,          32'd0};
        tbl[7]  = '{1'b1, A_CTRL,   32'h0000_0002,  32'd0};
        tbl[8]  = '{1'b0, A_CTRL,   32'd0,          32'h0000_0002};
        tbl[9]  = '{1'b0, A_STATUS, 32'd0,          32'h0000_0100};
        tbl[10] = '{1'b0, A_DATA,   32'd0,          32'd0};
        tbl[11] = '{1'b1, A_DATA,   32'h0001_2345,  32'd0};
        tbl[12] = '{1'b0, A_STATUS, 32'd0,          32'h0000_0100};
        tbl[13] = '{1'b1, A_CTRL,   32'd0,          32'd0};
        tbl[14] = '{1'b0, A_CTRL,   32'd0,          32'd0};
        tbl[15] = '{1'b0, A_MISSHI, 32'd0,          32'd0};

        // Reset with the alarm already high
        model_reset();
        alarm = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Alarm high at release is seen once, after the synchroniser fills
        bus(1'b1, A_CTRL, 32'd1, r);
        idle(4);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("sync_status", r, 32'h0000_0001);
        bus(1'b0, A_DATA, 32'd0, r);
        check("sync_ts", r, 32'h8000_0002);
        alarm = 1'b0;
        idle(2);

        // Register access vectors
        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d, r);
            if (!tbl[i].w) check($sformatf("tbl%0d", i), r, tbl[i].exp);
        end

        // Three pulses five cycles apart
        bus(1'b1, A_STATUS, 32'd1, r);
        bus(1'b1, A_CTRL, 32'd1, r);
        for (int i = 0; i < 3; i++) begin
            pulse(t[i]);
            idle(4);
        end
        idle(2);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("three_status", r, 32'h0000_0003);
        bus(1'b0, A_DATA, 32'd0, d1);
        bus(1'b0, A_DATA, 32'd0, d2);
        bus(1'b0, A_DATA, 32'd0, d3);
        check("three_d1", d1, 32'h8000_0000 | (t[0] + 2));
        check("three_bit31", 32'({d1[31], d2[31], d3[31]}), 32'd7);
        check("three_diff1", d2 - d1, 32'd5);
        check("three_diff2", d3 - d2, 32'd5);
        bus(1'b0, A_DATA, 32'd0, r);
        check("three_empty", r, 32'd0);

        // Ten pulses into an eight-deep FIFO
        for (int i = 0; i < 10; i++) begin
            pulse(t[i]);
            idle(2);
        end
        idle(3);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("ovf_status", r, 32'h0001_0208);
        bus(1'b1, A_STATUS, 32'h0001_0000, r);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("ovf_cleared", r, 32'h0000_0208);
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, A_DATA, 32'd0, r);
            check($sformatf("ovf_keep%0d", i), r, 32'h8000_0000 | (t[i] + 2));
        end
        bus(1'b0, A_STATUS, 32'd0, r);
        check("ovf_drained", r, 32'h0000_0100);

        // Interrupt behaviour
        bus(1'b1, A_CTRL, 32'd3, r);
        pulse(tt);
        idle(3);
        check("irq_set", 32'(irq), 32'd1);
        bus(1'b0, A_DATA, 32'd0, r);
        idle(1);
        check("irq_clear", 32'(irq), 32'd0);
        bus(1'b1, A_CTRL, 32'd2, r);
        pulse(tt);
        idle(5);
        check("irq_disabled", 32'(irq), 32'd0);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("disabled_status", r, 32'h0000_0100);

        // Full FIFO: push coincides with a DATA read
        bus(1'b1, A_CTRL, 32'd1, r);
        for (int i = 0; i < 8; i++) begin
            pulse(t[i]);
            idle(2);
        end
        idle(3);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("full_status", r, 32'h0000_0208);
        tt = ts_m;
        alarm = 1'b1;
        step();
        alarm = 1'b0;
        step();
        bus(1'b0, A_DATA, 32'd0, r);
        check("pp_head", r, 32'h8000_0000 | (t[0] + 2));
        bus(1'b0, A_STATUS, 32'd0, r);
        check("pp_status", r, 32'h0000_0208);
        for (int i = 1; i < 8; i++) begin
            bus(1'b0, A_DATA, 32'd0, r);
            check($sformatf("pp_keep%0d", i), r, 32'h8000_0000 | (t[i] + 2));
        end
        bus(1'b0, A_DATA, 32'd0, r);
        check("pp_tail", r, 32'h8000_0000 | (tt + 2));

        // Flush coincident with a push, overflow already set
        for (int i = 0; i < 9; i++) begin
            pulse(tt);
            idle(2);
        end
        idle(3);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("fl_pre", r, 32'h0001_0208);
        alarm = 1'b1;
        step();
        alarm = 1'b0;
        step();
        bus(1'b1, A_STATUS, 32'd1, r);
        idle(3);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("fl_status", r, 32'h0001_0100);
        bus(1'b1, A_STATUS, 32'h0001_0000, r);

        // Timestamp wrap on the narrow instance
        guard = 0;
        while (((ts_m & 32'h3FF) != 32'h3FF) && (guard < 2048)) begin
            step();
            guard++;
        end
        check("wrap_reached", 32'(ts_m & 32'h3FF), 32'h0000_03FF);
        tt = ts_m;
        bus(1'b0, A_TIME, 32'd0, r);
        check("wrap_time_max", rdata_w, 32'h0000_03FF);
        check("wrap_main_time", r, tt);
        check("wrap_ack", 32'(ack_w), 32'd1);
        bus(1'b0, A_TIME, 32'd0, r);
        check("wrap_time_zero", rdata_w, 32'd0);
        check("wrap_stall", 32'(stall_w), 32'd0);
        check("wrap_irq", 32'(irq_w), 32'd0);

        // Reset in the middle of a read with five entries queued
        bus(1'b1, A_STATUS, 32'd1, r);
        for (int i = 0; i < 5; i++) begin
            pulse(tt);
            idle(2);
        end
        idle(3);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("rst5_status", r, 32'h0000_0005);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_STATUS;
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_data", rdata, 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        bus(1'b0, A_TIME, 32'd0, r);
        check("rst_time", r, 32'd0);
        bus(1'b0, A_CTRL, 32'd0, r);
        check("rst_ctrl", r, 32'd0);
        bus(1'b0, A_STATUS, 32'd0, r);
        check("rst_status", r, 32'h0000_0100);

        // Randomised traffic against the model
        bus(1'b1, A_CTRL, 32'd3, r);
        for (int i = 0; i < 400; i++) begin
            alarm = ($urandom_range(3, 0) == 0);
            case ($urandom_range(9, 0))
                0, 1, 2, 3: step();
                4, 5:       bus(1'b0, A_DATA, 32'd0, r);
                6:          bus(1'b0, A_STATUS, 32'd0, r);
                7:          bus(1'b0, A_TIME, 32'd0, r);
                8:          bus(1'b1, A_CTRL, 32'($urandom_range(3, 0)), r);
                default: begin
                    if ($urandom_range(1, 0) == 0)
                        bus(1'b1, A_STATUS,
                            {15'd0, 1'($urandom_range(1, 0)), 15'd0, 1'($urandom_range(7, 0) == 0)}, r);
                    else
                        bus(1'b0, A_MISSHI, 32'd0, r);
                end
            endcase
        end
        alarm = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
